// File: rtl/run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : run_ctrl                                                      |
// | Purpose  : Run controller for one or more single-cycle cpu cores.        |
// |            Stretches the core reset after a start request, tracks        |
// |            per-core halts, counts RUN cycles and applies a watchdog.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module run_ctrl #(
  parameter int NUM_CORES  = 1,
  parameter int RST_HOLD   = 2,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] hlt,
  output logic                 core_rst_n,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [NUM_CORES-1:0] halt_mask
);

  // Hold counter only needs to count 0 .. RST_HOLD-1.
  localparam int               HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  WDOG_LIM  = CNT_W'(MAX_CYCLES);
  localparam bit                WDOG_EN   = (MAX_CYCLES != 0);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RSTHOLD = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  logic [2:0]           state_q,      state_d;
  logic [HOLD_W-1:0]    hold_cnt_q,   hold_cnt_d;
  logic [CNT_W-1:0]     cycle_cnt_q,  cycle_cnt_d;
  logic [NUM_CORES-1:0] halt_mask_q,  halt_mask_d;
  logic                 core_rst_n_q, core_rst_n_d;
  logic                 running_q,    running_d;
  logic                 done_q,       done_d;
  logic                 timeout_q,    timeout_d;

  // State, counters and registered outputs; rst_n clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      halt_mask_q  <= '0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      halt_mask_q  <= halt_mask_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and counter update; halt beats watchdog when both fire together.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    halt_mask_d = halt_mask_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          state_d     = ST_RSTHOLD;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
          halt_mask_d = '0;
        end
      end
      ST_RSTHOLD: begin
        // hlt from cores still in reset is meaningless, so it is not sampled here.
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        halt_mask_d = halt_mask_q | hlt;
        if (cycle_cnt_q != CNT_SAT) begin
          cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        end
        if (&halt_mask_d) begin
          state_d = ST_DONE;
        end else if (WDOG_EN && (cycle_cnt_d == WDOG_LIM)) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every flag lands with its state.
  always_comb begin
    core_rst_n_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    running_d    = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    timeout_d    = (state_d == ST_TIMEOUT);
  end

  assign core_rst_n = core_rst_n_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign halt_mask  = halt_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_run_ctrl                                                   |
// | Purpose  : Directed self-checking bench for run_ctrl. Three instances:   |
// |            single core, three cores, and watchdog disabled.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_run_ctrl;

  logic clk;
  logic rst_n;

  // Single-core instance, watchdog at 100.
  logic        start1;
  logic [0:0]  hlt1;
  logic        crn1, run1, done1, to1;
  logic [15:0] cnt1;
  logic [0:0]  mask1;

  // Three-core instance, watchdog at 100.
  logic        start3;
  logic [2:0]  hlt3;
  logic        crn3, run3, done3, to3;
  logic [15:0] cnt3;
  logic [2:0]  mask3;

  // Single-core instance, watchdog disabled.
  logic        start0;
  logic [0:0]  hlt0;
  logic        crn0, run0, done0, to0;
  logic [15:0] cnt0;
  logic [0:0]  mask0;

  int checks;
  int failures;

  run_ctrl #(.NUM_CORES(1), .RST_HOLD(2), .CNT_W(16), .MAX_CYCLES(100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .hlt(hlt1),
    .core_rst_n(crn1), .running(run1), .done(done1), .timeout(to1),
    .cycle_cnt(cnt1), .halt_mask(mask1)
  );

  run_ctrl #(.NUM_CORES(3), .RST_HOLD(2), .CNT_W(16), .MAX_CYCLES(100)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .hlt(hlt3),
    .core_rst_n(crn3), .running(run3), .done(done3), .timeout(to3),
    .cycle_cnt(cnt3), .halt_mask(mask3)
  );

  run_ctrl #(.NUM_CORES(1), .RST_HOLD(2), .CNT_W(16), .MAX_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .hlt(hlt0),
    .core_rst_n(crn0), .running(run0), .done(done0), .timeout(to0),
    .cycle_cnt(cnt0), .halt_mask(mask0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    start1 = 1'b0; hlt1 = 1'b0;
    start3 = 1'b0; hlt3 = 3'b000;
    start0 = 1'b0; hlt0 = 1'b0;

    // Reset held for 3 cycles, then idle with no start.
    repeat (3) tick();
    chk("rst_core_rst_n", {31'd0, crn1}, 32'd0);
    chk("rst_running",    {31'd0, run1}, 32'd0);
    chk("rst_done",       {31'd0, done1}, 32'd0);
    chk("rst_timeout",    {31'd0, to1}, 32'd0);
    chk("rst_cycle_cnt",  {16'd0, cnt1}, 32'd0);
    chk("rst_halt_mask3", {29'd0, mask3}, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_core_rst_n", {31'd0, crn1}, 32'd0);
    chk("idle_flags",      {29'd0, run1, done1, to1}, 32'd0);
    chk("idle_cycle_cnt",  {16'd0, cnt1}, 32'd0);

    // Normal halt, single core.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("hold1_core_rst_n", {31'd0, crn1}, 32'd0);
    chk("hold1_running",    {31'd0, run1}, 32'd0);
    tick();
    chk("hold2_core_rst_n", {31'd0, crn1}, 32'd0);
    tick();
    chk("run_core_rst_n", {31'd0, crn1}, 32'd1);
    chk("run_running",    {31'd0, run1}, 32'd1);
    chk("run_cnt0",       {16'd0, cnt1}, 32'd0);
    repeat (10) tick();
    chk("run_cnt10",  {16'd0, cnt1}, 32'd10);
    chk("run_done10", {31'd0, done1}, 32'd0);
    hlt1 = 1'b1;
    tick();
    chk("halt_done",       {31'd0, done1}, 32'd1);
    chk("halt_running",    {31'd0, run1}, 32'd0);
    chk("halt_cnt",        {16'd0, cnt1}, 32'd11);
    chk("halt_core_rst_n", {31'd0, crn1}, 32'd1);
    chk("halt_mask",       {31'd0, mask1}, 32'd1);
    hlt1 = 1'b0;
    tick();
    chk("done_frozen_cnt",  {16'd0, cnt1}, 32'd11);
    chk("done_frozen_mask", {31'd0, mask1}, 32'd1);
    chk("done_held",        {31'd0, done1}, 32'd1);

    // Restart from DONE; second run halts after 4 cycles.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("rs_done_cnt_clr",  {16'd0, cnt1}, 32'd0);
    chk("rs_done_mask_clr", {31'd0, mask1}, 32'd0);
    chk("rs_done_done",     {31'd0, done1}, 32'd0);
    chk("rs_done_crn",      {31'd0, crn1}, 32'd0);
    repeat (2) tick();
    chk("rs_done_running", {31'd0, run1}, 32'd1);
    repeat (3) tick();
    hlt1 = 1'b1;
    tick();
    chk("run2_done", {31'd0, done1}, 32'd1);
    chk("run2_cnt",  {16'd0, cnt1}, 32'd4);
    hlt1 = 1'b0;

    // Watchdog: no halt for 100 RUN cycles.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (2) tick();
    chk("wd_running", {31'd0, run1}, 32'd1);
    repeat (99) tick();
    chk("wd_cnt99",     {16'd0, cnt1}, 32'd99);
    chk("wd_to99",      {31'd0, to1}, 32'd0);
    chk("wd_running99", {31'd0, run1}, 32'd1);
    tick();
    chk("wd_timeout", {31'd0, to1}, 32'd1);
    chk("wd_cnt",     {16'd0, cnt1}, 32'd100);
    chk("wd_crn",     {31'd0, crn1}, 32'd0);
    chk("wd_done",    {31'd0, done1}, 32'd0);
    chk("wd_running", {31'd0, run1}, 32'd0);
    tick();
    chk("wd_cnt_frozen", {16'd0, cnt1}, 32'd100);

    // Restart from TIMEOUT; last halt lands on the watchdog cycle.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("rs_to_cnt_clr", {16'd0, cnt1}, 32'd0);
    chk("rs_to_timeout", {31'd0, to1}, 32'd0);
    chk("rs_to_crn",     {31'd0, crn1}, 32'd0);
    repeat (2) tick();
    repeat (99) tick();
    chk("sim_cnt99", {16'd0, cnt1}, 32'd99);
    hlt1 = 1'b1;
    tick();
    chk("sim_done",    {31'd0, done1}, 32'd1);
    chk("sim_timeout", {31'd0, to1}, 32'd0);
    chk("sim_cnt",     {16'd0, cnt1}, 32'd100);
    hlt1 = 1'b0;

    // Multi-core halt tracking.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    repeat (2) tick();
    chk("mc_running", {31'd0, run3}, 32'd1);
    repeat (5) tick();
    hlt3 = 3'b001;
    tick();
    chk("mc_mask001", {29'd0, mask3}, 32'd1);
    hlt3 = 3'b000;
    tick();
    chk("mc_sticky", {29'd0, mask3}, 32'd1);
    tick();
    chk("mc_cnt8", {16'd0, cnt3}, 32'd8);
    hlt3 = 3'b100;
    tick();
    chk("mc_mask101", {29'd0, mask3}, 32'd5);
    chk("mc_notdone", {31'd0, done3}, 32'd0);
    repeat (3) tick();
    hlt3 = 3'b110;
    tick();
    chk("mc_mask111", {29'd0, mask3}, 32'd7);
    chk("mc_done",    {31'd0, done3}, 32'd1);
    chk("mc_cnt13",   {16'd0, cnt3}, 32'd13);
    hlt3 = 3'b000;

    // Async reset mid-RUN on the multi-core instance.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    repeat (2) tick();
    repeat (5) tick();
    hlt3 = 3'b001;
    tick();
    chk("ar_pre_mask", {29'd0, mask3}, 32'd1);
    chk("ar_pre_run",  {31'd0, run3}, 32'd1);
    hlt3 = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_running", {31'd0, run3}, 32'd0);
    chk("ar_crn",     {31'd0, crn3}, 32'd0);
    chk("ar_cnt",     {16'd0, cnt3}, 32'd0);
    chk("ar_mask",    {29'd0, mask3}, 32'd0);
    chk("ar_done1",   {31'd0, done1}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Watchdog disabled: counter saturates, never times out.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (2) tick();
    chk("nw_running", {31'd0, run0}, 32'd1);
    repeat (100) tick();
    chk("nw_cnt100", {16'd0, cnt0}, 32'd100);
    chk("nw_to100",  {31'd0, to0}, 32'd0);
    repeat (65434) tick();
    chk("nw_cnt_fffe", {16'd0, cnt0}, 32'h0000_FFFE);
    tick();
    chk("nw_cnt_ffff", {16'd0, cnt0}, 32'h0000_FFFF);
    repeat (3) tick();
    chk("nw_cnt_sat",  {16'd0, cnt0}, 32'h0000_FFFF);
    chk("nw_to_sat",   {31'd0, to0}, 32'd0);
    chk("nw_run_sat",  {31'd0, run0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
